dii_packet_arbiter: RTL
=======================

DII_PACKET_ARBITER -- requirements
Module: dii_packet_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 2: number of DII requester ports (2..8).
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum words per packet before forced truncation (>=2).
REQ-003 SHALL have port clk  input  1: single clock; all state is in this domain.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  PORTS*16: requester data; port i occupies bits [16*i+15:16*i].
REQ-006 SHALL have port in_valid  input  PORTS: per-port word valid.
REQ-007 SHALL have port in_last  input  PORTS: per-port last word of packet.
REQ-008 SHALL have port in_ready  output  PORTS: per-port word accepted when valid&&ready.
REQ-009 SHALL have port out_data  output  16: arbitrated DII stream data, registered.
REQ-010 SHALL have port out_valid  output  1: output word valid, registered.
REQ-011 SHALL have port out_last  output  1: output last, registered.
REQ-012 SHALL have port out_ready  input  1: downstream accept.
REQ-013 SHALL have port grant  output  PORTS: one-hot current packet owner; all-zero when idle.
REQ-014 SHALL have port err_trunc  output  1: one-cycle pulse on forced truncation.

Function
REQ-015 SHALL arbitrate at packet granularity; an owner is never switched mid-packet.
REQ-016 SHALL implement states IDLE, XFER and DISCARD.
REQ-017 In IDLE, if any in_valid is high, SHALL select the first valid port searching round-robin from ptr+1 (mod PORTS), register the one-hot grant and enter XFER next cycle; no word is accepted in IDLE.
REQ-018 ptr SHALL hold the index of the last owner and update when a packet completes (XFER or DISCARD exit).
REQ-019 Output register SHALL be free when !out_valid || out_ready.
REQ-020 In XFER, in_ready[owner] SHALL equal "output register free"; all other in_ready bits SHALL be 0.
REQ-021 An accepted word SHALL be loaded into out_data/out_last with out_valid=1 on the next edge.
REQ-022 out_valid SHALL clear when out_ready is high and no new word is loaded that cycle.
REQ-023 Output SHALL hold data/last/valid stable while out_valid && !out_ready.
REQ-024 A 5-bit-minimum word counter SHALL clear on entering XFER and increment per accepted word.
REQ-025 An accepted word with in_last=1 in XFER SHALL return the block to IDLE and clear grant on the same edge.
REQ-026 When the accepted word is number MAX_LEN and in_last=0: SHALL emit it with out_last forced to 1, pulse err_trunc for one cycle, and enter DISCARD.
REQ-027 In DISCARD, in_ready[owner] SHALL be 1 unconditionally; accepted words SHALL be dropped, not output; accepting in_last=1 SHALL return to IDLE.
REQ-028 A word with in_last=1 that is also word MAX_LEN SHALL complete normally with no err_trunc.
REQ-029 Minimum packet-to-packet turnaround SHALL be one IDLE cycle between an owner's last accept and the next grant.
REQ-030 Requester latency: in_valid high in cycle N while IDLE yields grant in N+1, first accept in N+1 if output free, out_valid in N+2.
REQ-031 Deasserting in_valid mid-packet SHALL stall the transfer without releasing grant.

Reset
REQ-032 On rst: state=IDLE, grant=0, in_ready=0, out_valid=0, out_last=0, out_data=0, err_trunc=0, counter=0, ptr=PORTS-1 (port 0 has first priority).
REQ-033 Reset asserted mid-packet SHALL abort immediately; the partial packet is lost and no out_last is emitted.

Verification
REQ-034 Reset release, port0 sends 3-word packet 0x0001,0x0002,0x0003(last), out_ready=1 -> grant=01 one cycle after valid, out words in order, out_last on 0x0003, grant=00 after.
REQ-035 Both ports continuously send 2-word packets -> owners alternate 0,1,0,1; no interleaving within a packet.
REQ-036 Port1 packet with out_ready held low 4 cycles mid-packet -> out_data/out_last stable, in_ready[1]=0 while the output register is full, no word lost or duplicated.
REQ-037 MAX_LEN=4, port0 sends 6-word packet -> 4 words out, 4th with out_last=1, err_trunc one pulse, words 5-6 dropped, next packet proceeds normally.
REQ-038 rst asserted after word 2 of a 5-word packet -> all outputs 0 immediately; after release, port 0 wins a simultaneous request.
REQ-039 Exactly MAX_LEN-word packet ending with in_last -> no err_trunc, normal return to IDLE.

Source files
------------

// File: rtl/dii_packet_arbiter.sv
// dii_packet_arbiter
//   Packet-granular round-robin arbiter that merges PORTS 16-bit DII
//   requester streams into one registered output stream. Once a port
//   owns the output it keeps it until its last word. A packet longer
//   than MAX_LEN words is cut: word MAX_LEN goes out with out_last forced
//   high, err_trunc pulses, and the rest of the packet is drained and
//   dropped.
// Ports
//   clk, rst             clock, async active-high reset
//   in_data/valid/last   per-port requester stream (port i = bits [16i+15:16i])
//   in_ready             per-port accept (only the current owner can be ready)
//   out_data/valid/last  registered arbitrated stream
//   out_ready            downstream accept
//   grant                one-hot current owner, zero when idle
//   err_trunc            one-cycle pulse, aligned with the forced-last word
module dii_packet_arbiter #(
  parameter int PORTS   = 2,
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTS*16-1:0] in_data,
  input  logic [PORTS-1:0]   in_valid,
  input  logic [PORTS-1:0]   in_last,
  output logic [PORTS-1:0]   in_ready,
  output logic [15:0]        out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic [PORTS-1:0]   grant,
  output logic               err_trunc
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = ($clog2(MAX_LEN + 1) > 5) ? $clog2(MAX_LEN + 1) : 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DISC = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [IW-1:0]    own_q, own_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      odata_q, odata_d;
  logic             olast_q, olast_d;
  logic             oval_q, oval_d;
  logic             err_q, err_d;

  logic [PORTS-1:0][15:0] in_words;
  logic          out_free, own_vld, own_last, acc_x, acc_d, at_max;
  logic [IW-1:0] rr_idx, rr_sel;
  logic          rr_hit;

  assign in_words = in_data;
  assign out_free = !oval_q || out_ready;
  assign own_vld  = in_valid[own_q];
  assign own_last = in_last[own_q];
  assign acc_x    = (state_q == S_XFER) && own_vld && out_free;
  assign acc_d    = (state_q == S_DISC) && own_vld;
  // cnt_q holds words already accepted, so this word is number MAX_LEN
  assign at_max   = (cnt_q == CW'(MAX_LEN - 1));

  // Round-robin search starting just after the last owner.
  always_comb begin
    rr_idx = '0;
    rr_sel = '0;
    rr_hit = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      rr_idx = IW'((int'(ptr_q) + k) % PORTS);
      if (!rr_hit && in_valid[rr_idx]) begin
        rr_hit = 1'b1;
        rr_sel = rr_idx;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (state_q == S_XFER) in_ready[own_q] = out_free;
    if (state_q == S_DISC) in_ready[own_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    odata_d = odata_q;
    olast_d = olast_q;
    oval_d  = oval_q;
    err_d   = 1'b0;

    if (acc_x) begin
      odata_d = in_words[own_q];
      olast_d = own_last || at_max;
      oval_d  = 1'b1;
    end else if (out_ready) begin
      oval_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rr_hit) begin
          state_d         = S_XFER;
          own_d           = rr_sel;
          grant_d         = '0;
          grant_d[rr_sel] = 1'b1;
          cnt_d           = '0;
        end
      end
      S_XFER: begin
        if (acc_x) begin
          cnt_d = cnt_q + 1'b1;
          if (own_last) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = own_q;
          end else if (at_max) begin
            state_d = S_DISC;
            err_d   = 1'b1;
          end
        end
      end
      S_DISC: begin
        if (acc_d && own_last) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = own_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= IW'(PORTS - 1);
      cnt_q   <= '0;
      odata_q <= '0;
      olast_q <= 1'b0;
      oval_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      odata_q <= odata_d;
      olast_q <= olast_d;
      oval_q  <= oval_d;
      err_q   <= err_d;
    end
  end

  assign out_data  = odata_q;
  assign out_last  = olast_q;
  assign out_valid = oval_q;
  assign grant     = grant_q;
  assign err_trunc = err_q;

endmodule
